// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path.
package rv_ctrl_pkg;

    // Supported opcodes
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMemRd,
        StMemWr,
        StWb,
        StTrap
    } state_e;

    // alu_ctrl codes are {funct7_5, funct3}
    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b1000;

    localparam logic [2:0] ImmI = 3'd0;
    localparam logic [2:0] ImmS = 3'd1;
    localparam logic [2:0] ImmB = 3'd2;
    localparam logic [2:0] ImmU = 3'd3;

    localparam logic [1:0] WbAlu = 2'd0;
    localparam logic [1:0] WbMem = 2'd1;
    localparam logic [1:0] WbImm = 2'd2;

    localparam logic PcPlus4  = 1'b0;
    localparam logic PcBranch = 1'b1;

    localparam logic [1:0] SrcBRs2  = 2'd0;
    localparam logic [1:0] SrcBImm  = 2'd1;
    localparam logic [1:0] SrcBFour = 2'd2;

    localparam logic [1:0] CauseNone       = 2'd0;
    localparam logic [1:0] CauseIllegal    = 2'd1;
    localparam logic [1:0] CauseMemTimeout = 2'd2;

    function automatic logic op_supported(logic [6:0] op);
        return (op == OpR) || (op == OpImm) || (op == OpLoad) || (op == OpStore) ||
               (op == OpBranch) || (op == OpLui);
    endfunction

    // funct3 010/011 have no branch meaning
    function automatic logic branch_f3_legal(logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

    function automatic logic branch_taken(logic [2:0] f3, logic eq, logic lt, logic ltu);
        logic taken;
        case (f3)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/rv_alu_ctrl_dec.sv
// Combinational ALU operation decode from opcode/funct3/funct7_5.
module rv_alu_ctrl_dec
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [3:0] alu_ctrl_o
);

    // Only SRAI among immediates uses instruction[30]; branches compare via subtract
    always_comb begin
        alu_ctrl_o = AluAdd;
        case (op_i)
            OpR:      alu_ctrl_o = {funct7_5_i, funct3_i};
            OpImm:    alu_ctrl_o = {funct7_5_i & (funct3_i == 3'b101), funct3_i};
            OpBranch: alu_ctrl_o = AluSub;
            default:  alu_ctrl_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences shared memory port, decoder and ALU.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [6:0]       op_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7_5_i,
    input  logic             mem_ready_i,
    input  logic             alu_eq_i,
    input  logic             alu_lt_i,
    input  logic             alu_ltu_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             addr_sel_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       imm_sel_o,
    output logic [3:0]       alu_ctrl_o,
    output logic             reg_write_o,
    output logic [1:0]       wb_sel_o,
    output logic             mdr_write_o,
    output logic             trap_o,
    output logic [1:0]       trap_cause_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [1:0]         trap_cause_q, trap_cause_d;
    logic [3:0]         alu_ctrl_dec;
    logic               retire;
    logic               mem_timeout;

    rv_alu_ctrl_dec u_alu_ctrl_dec (
        .op_i       (op_i),
        .funct3_i   (funct3_i),
        .funct7_5_i (funct7_5_i),
        .alu_ctrl_o (alu_ctrl_dec)
    );

    // Last permitted wait cycle: no ready now means give up
    assign mem_timeout = (wait_cnt_q == WaitW'(MEM_TIMEOUT - 1));

    // State, wait counter, retire counter and trap cause registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StFetch;
            wait_cnt_q   <= '0;
            instret_q    <= '0;
            trap_cause_q <= CauseNone;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            instret_q    <= instret_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Next-state and output decode; everything forced to 0 while reset is high
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        instret_d    = instret_q;
        trap_cause_d = trap_cause_q;
        retire       = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        addr_sel_o   = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = PcPlus4;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SrcBRs2;
        imm_sel_o    = ImmI;
        alu_ctrl_o   = AluAdd;
        reg_write_o  = 1'b0;
        wb_sel_o     = WbAlu;
        mdr_write_o  = 1'b0;
        trap_o       = 1'b0;
        trap_cause_o = CauseNone;
        instret_o    = '0;

        if (!reset_i) begin
            unique case (state_q)
                StFetch: begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                        state_d    = StDecode;
                    end else if (mem_timeout) begin
                        state_d      = StTrap;
                        trap_cause_d = CauseMemTimeout;
                    end
                end
                StDecode: begin
                    if (op_supported(op_i)) begin
                        state_d = StExec;
                    end else begin
                        state_d      = StTrap;
                        trap_cause_d = CauseIllegal;
                    end
                end
                StExec: begin
                    alu_ctrl_o = alu_ctrl_dec;
                    case (op_i)
                        OpR: state_d = StWb;
                        OpImm: begin
                            alu_src_b_o = SrcBImm;
                            state_d     = StWb;
                        end
                        OpLoad: begin
                            alu_src_b_o = SrcBImm;
                            state_d     = StMemRd;
                        end
                        OpStore: begin
                            alu_src_b_o = SrcBImm;
                            imm_sel_o   = ImmS;
                            state_d     = StMemWr;
                        end
                        OpLui: begin
                            imm_sel_o = ImmU;
                            state_d   = StWb;
                        end
                        OpBranch: begin
                            imm_sel_o = ImmB;
                            if (!branch_f3_legal(funct3_i)) begin
                                state_d      = StTrap;
                                trap_cause_d = CauseIllegal;
                            end else begin
                                if (branch_taken(funct3_i, alu_eq_i, alu_lt_i, alu_ltu_i)) begin
                                    pc_write_o = 1'b1;
                                    pc_src_o   = PcBranch;
                                end
                                retire  = 1'b1;
                                state_d = StFetch;
                            end
                        end
                        default: begin
                            state_d      = StTrap;
                            trap_cause_d = CauseIllegal;
                        end
                    endcase
                end
                StMemRd: begin
                    mem_req_o  = 1'b1;
                    addr_sel_o = 1'b1;
                    if (mem_ready_i) begin
                        mdr_write_o = 1'b1;
                        state_d     = StWb;
                    end else if (mem_timeout) begin
                        state_d      = StTrap;
                        trap_cause_d = CauseMemTimeout;
                    end
                end
                StMemWr: begin
                    mem_req_o  = 1'b1;
                    mem_we_o   = 1'b1;
                    addr_sel_o = 1'b1;
                    if (mem_ready_i) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else if (mem_timeout) begin
                        state_d      = StTrap;
                        trap_cause_d = CauseMemTimeout;
                    end
                end
                StWb: begin
                    reg_write_o = 1'b1;
                    if (op_i == OpLoad) begin
                        wb_sel_o = WbMem;
                    end else if (op_i == OpLui) begin
                        wb_sel_o = WbImm;
                    end
                    retire  = 1'b1;
                    state_d = StFetch;
                end
                StTrap: trap_o = 1'b1;
                default: state_d = StFetch;
            endcase

            // Any state change restarts the wait count, so each mem state starts from zero
            if (state_d != state_q) begin
                wait_cnt_d = '0;
            end else if (mem_req_o && !mem_ready_i) begin
                wait_cnt_d = wait_cnt_q + WaitW'(1);
            end

            if (retire) begin
                instret_d = instret_q + CNT_W'(1);
            end

            trap_cause_o = trap_cause_q;
            instret_o    = instret_q;
        end
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench: per-cycle expected outputs queued with stimulus, popped and compared.
module tb_rv_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_sel;
        logic [3:0] alu_ctrl;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       mdr_write;
        logic       trap;
        logic [1:0] trap_cause;
    } ov_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        eq;
        logic        lt;
        logic        ltu;
        ov_t         ov;
        logic [31:0] ir;
    } cyc_t;

    typedef struct {
        logic [2:0] f3;
        logic       eq;
        logic       lt;
        logic       ltu;
        logic       taken;
    } br_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7_5 = 1'b0;
    logic        mem_ready = 1'b0;
    logic        alu_eq = 1'b0;
    logic        alu_lt = 1'b0;
    logic        alu_ltu = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0]  alu_src_b, wb_sel, trap_cause;
    logic [2:0]  imm_sel;
    logic [3:0]  alu_ctrl;
    logic        reg_write, mdr_write, trap;
    logic [31:0] instret;
    ov_t         obs;

    int          n_vec = 0;
    int          n_err = 0;
    cyc_t        exp_q[$];
    logic [31:0] exp_ir = '0;
    logic [6:0]  cur_op = '0;
    logic [2:0]  cur_f3 = '0;
    logic        cur_f7 = 1'b0;
    logic        cur_eq = 1'b0;
    logic        cur_lt = 1'b0;
    logic        cur_ltu = 1'b0;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(
        .MEM_TIMEOUT (16),
        .CNT_W       (32)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .op_i         (op),
        .funct3_i     (funct3),
        .funct7_5_i   (funct7_5),
        .mem_ready_i  (mem_ready),
        .alu_eq_i     (alu_eq),
        .alu_lt_i     (alu_lt),
        .alu_ltu_i    (alu_ltu),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .addr_sel_o   (addr_sel),
        .ir_write_o   (ir_write),
        .pc_write_o   (pc_write),
        .pc_src_o     (pc_src),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .imm_sel_o    (imm_sel),
        .alu_ctrl_o   (alu_ctrl),
        .reg_write_o  (reg_write),
        .wb_sel_o     (wb_sel),
        .mdr_write_o  (mdr_write),
        .trap_o       (trap),
        .trap_cause_o (trap_cause),
        .instret_o    (instret)
    );

    assign obs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                  imm_sel, alu_ctrl, reg_write, wb_sel, mdr_write, trap, trap_cause};

    // ---- expected-record builders (push onto scoreboard) ----
    function automatic void set_ins(logic [6:0] o, logic [2:0] f3, logic f7);
        cur_op = o;
        cur_f3 = f3;
        cur_f7 = f7;
    endfunction

    function automatic cyc_t base();
        cyc_t r;
        r.rst = 1'b0;
        r.rdy = 1'b0;
        r.op  = cur_op;
        r.f3  = cur_f3;
        r.f7  = cur_f7;
        r.eq  = cur_eq;
        r.lt  = cur_lt;
        r.ltu = cur_ltu;
        r.ov  = '0;
        r.ir  = exp_ir;
        return r;
    endfunction

    function automatic void p_rst();
        cyc_t r = base();
        r.rst = 1'b1;
        r.rdy = 1'b1;
        r.ir  = '0;
        exp_q.push_back(r);
        exp_ir = '0;
    endfunction

    function automatic void p_fetch(logic rdy);
        cyc_t r = base();
        r.rdy         = rdy;
        r.ov.mem_req  = 1'b1;
        r.ov.ir_write = rdy;
        r.ov.pc_write = rdy;
        exp_q.push_back(r);
    endfunction

    function automatic void p_idle();
        exp_q.push_back(base());
    endfunction

    function automatic void p_exec(logic [1:0] srcb, logic [2:0] imm, logic [3:0] alu,
                                   logic taken, logic ret);
        cyc_t r = base();
        r.ov.alu_src_b = srcb;
        r.ov.imm_sel   = imm;
        r.ov.alu_ctrl  = alu;
        r.ov.pc_write  = taken;
        r.ov.pc_src    = taken;
        exp_q.push_back(r);
        if (ret) exp_ir = exp_ir + 1;
    endfunction

    function automatic void p_mem(logic we, logic rdy);
        cyc_t r = base();
        r.rdy          = rdy;
        r.ov.mem_req   = 1'b1;
        r.ov.mem_we    = we;
        r.ov.addr_sel  = 1'b1;
        r.ov.mdr_write = !we && rdy;
        exp_q.push_back(r);
        if (we && rdy) exp_ir = exp_ir + 1;
    endfunction

    function automatic void p_wb(logic [1:0] wbs);
        cyc_t r = base();
        r.ov.reg_write = 1'b1;
        r.ov.wb_sel    = wbs;
        exp_q.push_back(r);
        exp_ir = exp_ir + 1;
    endfunction

    function automatic void p_trap(logic [1:0] cause);
        cyc_t r = base();
        r.ov.trap       = 1'b1;
        r.ov.trap_cause = cause;
        exp_q.push_back(r);
    endfunction

    task automatic drive(input cyc_t r);
        reset     = r.rst;
        mem_ready = r.rdy;
        op        = r.op;
        funct3    = r.f3;
        funct7_5  = r.f7;
        alu_eq    = r.eq;
        alu_lt    = r.lt;
        alu_ltu   = r.ltu;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        cyc_t r;
        int   i = 0;
        set_ins(7'b0110011, 3'b000, 1'b0);
        p_rst();
        p_rst();
        while (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            drive(r);
            @(negedge clk);
            n_vec++;
            if (obs !== r.ov || instret !== r.ir) begin
                n_err++;
                $display("FAIL reset[%0d]: got ov=%h instret=%0d, want ov=%h instret=%0d",
                         i, obs, instret, r.ov, r.ir);
            end
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic test_alu_ops();
        cyc_t r;
        int   i = 0;
        // ADD, zero-wait: F D E WB
        set_ins(7'b0110011, 3'b000, 1'b0);
        p_fetch(1'b1); p_idle(); p_exec(2'd0, 3'd0, 4'b0000, 1'b0, 1'b0); p_wb(2'd0);
        // SUB
        set_ins(7'b0110011, 3'b000, 1'b1);
        p_fetch(1'b1); p_idle(); p_exec(2'd0, 3'd0, 4'b1000, 1'b0, 1'b0); p_wb(2'd0);
        // SRAI
        set_ins(7'b0010011, 3'b101, 1'b1);
        p_fetch(1'b1); p_idle(); p_exec(2'd1, 3'd0, 4'b1101, 1'b0, 1'b0); p_wb(2'd0);
        // ADDI with instruction[30] set must stay ADD
        set_ins(7'b0010011, 3'b000, 1'b1);
        p_fetch(1'b1); p_idle(); p_exec(2'd1, 3'd0, 4'b0000, 1'b0, 1'b0); p_wb(2'd0);
        // LUI
        set_ins(7'b0110111, 3'b011, 1'b1);
        p_fetch(1'b1); p_idle(); p_exec(2'd0, 3'd3, 4'b0000, 1'b0, 1'b0); p_wb(2'd2);
        while (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            drive(r);
            @(negedge clk);
            n_vec++;
            if (obs !== r.ov || instret !== r.ir) begin
                n_err++;
                $display("FAIL alu_ops[%0d]: got ov=%h instret=%0d, want ov=%h instret=%0d",
                         i, obs, instret, r.ov, r.ir);
            end
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic test_load_store();
        cyc_t r;
        int   i = 0;
        // LW with 3 wait cycles in MEM_RD: 8 cycles total
        set_ins(7'b0000011, 3'b010, 1'b0);
        p_fetch(1'b1); p_idle(); p_exec(2'd1, 3'd0, 4'b0000, 1'b0, 1'b0);
        p_mem(1'b0, 1'b0); p_mem(1'b0, 1'b0); p_mem(1'b0, 1'b0); p_mem(1'b0, 1'b1);
        p_wb(2'd1);
        // SW with one fetch wait and zero-wait store
        set_ins(7'b0100011, 3'b010, 1'b0);
        p_fetch(1'b0); p_fetch(1'b1); p_idle(); p_exec(2'd1, 3'd1, 4'b0000, 1'b0, 1'b0);
        p_mem(1'b1, 1'b1);
        while (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            drive(r);
            @(negedge clk);
            n_vec++;
            if (obs !== r.ov || instret !== r.ir) begin
                n_err++;
                $display("FAIL load_store[%0d]: got ov=%h instret=%0d, want ov=%h instret=%0d",
                         i, obs, instret, r.ov, r.ir);
            end
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic test_branch();
        cyc_t r;
        int   i = 0;
        br_t  tbl [8];
        tbl = '{'{3'b000, 1'b1, 1'b0, 1'b0, 1'b1}, '{3'b000, 1'b0, 1'b1, 1'b1, 1'b0},
                '{3'b001, 1'b0, 1'b0, 1'b0, 1'b1}, '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0},
                '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1}, '{3'b101, 1'b0, 1'b1, 1'b0, 1'b0},
                '{3'b110, 1'b0, 1'b1, 1'b0, 1'b0}, '{3'b111, 1'b0, 1'b1, 1'b0, 1'b1}};
        // Back-to-back branches, each F D E and retiring
        for (int k = 0; k < 8; k++) begin
            set_ins(7'b1100011, tbl[k].f3, 1'b0);
            cur_eq  = tbl[k].eq;
            cur_lt  = tbl[k].lt;
            cur_ltu = tbl[k].ltu;
            p_fetch(1'b1); p_idle(); p_exec(2'd0, 3'd2, 4'b1000, tbl[k].taken, 1'b1);
        end
        cur_eq = 1'b0; cur_lt = 1'b0; cur_ltu = 1'b0;
        while (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            drive(r);
            @(negedge clk);
            n_vec++;
            if (obs !== r.ov || instret !== r.ir) begin
                n_err++;
                $display("FAIL branch[%0d]: got ov=%h instret=%0d, want ov=%h instret=%0d",
                         i, obs, instret, r.ov, r.ir);
            end
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic test_trap();
        cyc_t r;
        int   i = 0;
        // Illegal opcode: trap after DECODE, count unchanged
        set_ins(7'b1111111, 3'b000, 1'b0);
        p_fetch(1'b1); p_idle(); p_trap(2'd1); p_trap(2'd1); p_trap(2'd1);
        p_rst();
        // Fetch never answered: 16 wait cycles then trap cause 2
        set_ins(7'b0110011, 3'b000, 1'b0);
        for (int k = 0; k < 16; k++) p_fetch(1'b0);
        p_trap(2'd2); p_trap(2'd2);
        p_rst();
        // Illegal branch funct3 traps from EXEC
        set_ins(7'b1100011, 3'b010, 1'b0);
        p_fetch(1'b1); p_idle(); p_exec(2'd0, 3'd2, 4'b1000, 1'b0, 1'b0); p_trap(2'd1);
        p_rst();
        // Core runs again after reset
        set_ins(7'b0110011, 3'b000, 1'b0);
        p_fetch(1'b1); p_idle(); p_exec(2'd0, 3'd0, 4'b0000, 1'b0, 1'b0); p_wb(2'd0);
        p_fetch(1'b0);
        while (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            drive(r);
            @(negedge clk);
            n_vec++;
            if (obs !== r.ov || instret !== r.ir) begin
                n_err++;
                $display("FAIL trap[%0d]: got ov=%h instret=%0d, want ov=%h instret=%0d",
                         i, obs, instret, r.ov, r.ir);
            end
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic test_reset_mid_store();
        cyc_t r;
        int   i = 0;
        set_ins(7'b0110011, 3'b000, 1'b0);
        p_fetch(1'b1); p_idle(); p_exec(2'd0, 3'd0, 4'b0000, 1'b0, 1'b0); p_wb(2'd0);
        set_ins(7'b0100011, 3'b010, 1'b0);
        p_fetch(1'b1); p_idle(); p_exec(2'd1, 3'd1, 4'b0000, 1'b0, 1'b0);
        p_mem(1'b1, 1'b0); p_mem(1'b1, 1'b0);
        p_rst();
        // Restarts in FETCH with a cleared count
        p_fetch(1'b1); p_idle(); p_exec(2'd1, 3'd1, 4'b0000, 1'b0, 1'b0); p_mem(1'b1, 1'b1);
        p_fetch(1'b0);
        while (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            drive(r);
            @(negedge clk);
            n_vec++;
            if (obs !== r.ov || instret !== r.ir) begin
                n_err++;
                $display("FAIL reset_mid_store[%0d]: got ov=%h instret=%0d, want ov=%h instret=%0d",
                         i, obs, instret, r.ov, r.ir);
            end
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_load_store();
        test_branch();
        test_trap();
        test_reset_mid_store();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
